// File: rtl/controlador_entrada_saida_pkg.sv
// Shared definitions for the I/O controller: FSM state encodings, data widths
// and the switch sign-extension helper. The control unit imports the same
// package, so the debug state value decodes the same way on both sides.
package controlador_entrada_saida_pkg;

   localparam int LARGURA_SWITCH = 9;
   localparam int LARGURA_DADO   = 32;

   typedef enum logic [2:0] {
      OCIOSO              = 3'd0,
      ESPERA_SOLTA        = 3'd1,
      ESPERA_APERTO       = 3'd2,
      ESCREVE             = 3'd3,
      SAIDA_ESPERA_SOLTA  = 3'd4,
      SAIDA_ESPERA_APERTO = 3'd5
   } estadoT;

   // Replicates the switch sign bit into the upper bits of the data word.
   function automatic logic [LARGURA_DADO-1:0] estendeSinal(input logic [LARGURA_SWITCH-1:0] valor);
      return {{(LARGURA_DADO-LARGURA_SWITCH){valor[LARGURA_SWITCH-1]}}, valor};
   endfunction

endpackage

// File: rtl/controlador_entrada_saida_if.sv
// Bundle of the signals exchanged between the I/O controller, the control
// unit / register bank and the board-level switches, button and display.
interface controlador_entrada_saida_if;
   import controlador_entrada_saida_pkg::*;

   logic                      enter;
   logic [LARGURA_SWITCH-1:0] entradaSwitch;
   logic                      pedidoEntrada;
   logic                      pedidoSaida;
   logic [LARGURA_DADO-1:0]   dadoSaidaBanco;
   logic [LARGURA_DADO-1:0]   dadoEntrada;
   logic                      escreveBanco;
   logic                      pcHabilita;
   logic [LARGURA_DADO-1:0]   dadoDisplay;
   logic                      displayValido;
   logic [2:0]                estado;

   // Side that drives requests, raw button and switches (control unit / board).
   modport master (
      output enter, entradaSwitch, pedidoEntrada, pedidoSaida, dadoSaidaBanco,
      input  dadoEntrada, escreveBanco, pcHabilita, dadoDisplay, displayValido, estado
   );

   // The I/O controller itself.
   modport slave (
      input  enter, entradaSwitch, pedidoEntrada, pedidoSaida, dadoSaidaBanco,
      output dadoEntrada, escreveBanco, pcHabilita, dadoDisplay, displayValido, estado
   );

endinterface

// File: rtl/controlador_entrada_saida_debounce.sv
// Synchronizer plus debounce for the enter pushbutton. The raw button goes
// through two flops, then a saturating counter tracks how many consecutive
// synchronized samples matched the level the FSM is waiting for. estavel
// pulses on the sample that completes the required run.
module sincronizadorDebounce #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int LARGURA_CONT    = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic enter,
   input  logic nivelEsperado,
   input  logic limpa,
   output logic estavel
);

   localparam logic [LARGURA_CONT-1:0] ALVO = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
   localparam logic [LARGURA_CONT-1:0] TETO = LARGURA_CONT'(DEBOUNCE_CICLOS);

   logic                    sinc1;
   logic                    sinc2;
   logic [LARGURA_CONT-1:0] contador;
   logic                    concorda;

   assign concorda = (sinc2 == nivelEsperado);

   // Two-flop synchronizer; resets to "released" so a reset never looks like a press.
   always_ff @(posedge clock) begin
      if (reset) begin
         sinc1 <= 1'b1;
         sinc2 <= 1'b1;
      end else begin
         sinc1 <= enter;
         sinc2 <= sinc1;
      end
   end

   // Run-length counter: cleared by a disagreeing sample or a state change, saturates instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset || limpa || !concorda) begin
         contador <= '0;
      end else if (contador != TETO) begin
         contador <= contador + 1'b1;
      end
   end

   assign estavel = concorda && (contador == ALVO);

endmodule

// File: rtl/controlador_entrada_saida.sv
// I/O controller: stalls the program counter while an input or output
// instruction waits for the operator to release and then press enter.
// Input instructions latch the sign-extended switches and pulse a register
// bank write; output instructions capture a register value for the display.
module controlador_entrada_saida
   import controlador_entrada_saida_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int LARGURA_CONT    = 8
) (
   input logic                           clock,
   input logic                           reset,
   controlador_entrada_saida_if.slave    es
);

   estadoT                  estado;
   estadoT                  estadoProx;
   logic                    estavel;
   logic                    nivelEsperado;
   logic                    limpa;
   logic                    escreveBanco;
   logic                    pcHabilita;
   logic [LARGURA_DADO-1:0] dadoEntradaReg;
   logic [LARGURA_DADO-1:0] dadoDisplayReg;
   logic                    displayValidoReg;

   sincronizadorDebounce #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
      .LARGURA_CONT   (LARGURA_CONT)
   ) uDebounce (
      .clock        (clock),
      .reset        (reset),
      .enter        (es.enter),
      .nivelEsperado(nivelEsperado),
      .limpa        (limpa),
      .estavel      (estavel)
   );

   assign limpa = (estadoProx != estado);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= estadoProx;
      end
   end

   // Next-state and Moore/Mealy outputs; requests are only looked at while idle.
   always_comb begin
      estadoProx    = estado;
      nivelEsperado = 1'b1;
      escreveBanco  = 1'b0;
      pcHabilita    = 1'b0;
      case (estado)
         OCIOSO: begin
            pcHabilita = !(es.pedidoEntrada || es.pedidoSaida);
            if (es.pedidoEntrada) begin
               estadoProx = ESPERA_SOLTA;
            end else if (es.pedidoSaida) begin
               estadoProx = SAIDA_ESPERA_SOLTA;
            end
         end
         ESPERA_SOLTA: begin
            nivelEsperado = 1'b1;
            if (estavel) estadoProx = ESPERA_APERTO;
         end
         ESPERA_APERTO: begin
            nivelEsperado = 1'b0;
            if (estavel) estadoProx = ESCREVE;
         end
         ESCREVE: begin
            escreveBanco = 1'b1;
            estadoProx   = OCIOSO;
         end
         SAIDA_ESPERA_SOLTA: begin
            nivelEsperado = 1'b1;
            if (estavel) estadoProx = SAIDA_ESPERA_APERTO;
         end
         SAIDA_ESPERA_APERTO: begin
            nivelEsperado = 1'b0;
            if (estavel) estadoProx = OCIOSO;
         end
         default: begin
            estadoProx = OCIOSO;
         end
      endcase
   end

   // Data registers: switches captured on the accepted press, display captured when an output starts.
   always_ff @(posedge clock) begin
      if (reset) begin
         dadoEntradaReg   <= '0;
         dadoDisplayReg   <= '0;
         displayValidoReg <= 1'b0;
      end else begin
         if (estado == ESPERA_APERTO && estavel) begin
            dadoEntradaReg <= estendeSinal(es.entradaSwitch);
         end
         if (estado == OCIOSO && !es.pedidoEntrada && es.pedidoSaida) begin
            dadoDisplayReg   <= es.dadoSaidaBanco;
            displayValidoReg <= 1'b1;
         end
      end
   end

   assign es.dadoEntrada   = dadoEntradaReg;
   assign es.escreveBanco  = escreveBanco;
   assign es.pcHabilita    = pcHabilita;
   assign es.dadoDisplay   = dadoDisplayReg;
   assign es.displayValido = displayValidoReg;
   assign es.estado        = estado;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Testbench for the I/O controller: directed scenarios for the main
// transactions plus a randomized phase, all checked every cycle against a
// transaction-level model of the controller kept here.
module tb_controlador_entrada_saida;
   import controlador_entrada_saida_pkg::*;

   localparam int DEB = 4;

   logic clock;
   logic reset;
   int   assertCount;
   int   failCount;
   int   writeCount;

   controlador_entrada_saida_if es();

   controlador_entrada_saida #(
      .DEBOUNCE_CICLOS(DEB),
      .LARGURA_CONT   (8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .es   (es)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model state: phase of the transaction, run of matching button samples and held data.
   estadoT      mEstado;
   int          run;
   logic        d0;
   logic        d1;
   logic        amostra;
   logic        aguardado;
   logic [31:0] mDadoEntrada;
   logic [31:0] mDisplay;
   logic        mValido;
   bit          modeloAtivo;

   initial begin
      modeloAtivo = 1'b0;
      d0 = 1'b1;
      d1 = 1'b1;
   end

   task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      assertCount++;
      if (atual !== esperado) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [8:0] sw, input logic pe,
                                input logic ps, input logic [31:0] banco);
      es.enter          = en;
      es.entradaSwitch  = sw;
      es.pedidoEntrada  = pe;
      es.pedidoSaida    = ps;
      es.dadoSaidaBanco = banco;
   endtask

   task automatic waitEstado(input estadoT alvo, input int limite, input string nome);
      int n = 0;
      while (es.estado !== 3'(alvo) && n < limite) begin
         tick(1);
         n++;
      end
      checkOutput(nome, 32'(es.estado), 32'(alvo));
   endtask

   // Transaction-level reference: the button is seen two edges late, and each waiting
   // phase needs DEB consecutive samples at the awaited level.
   always @(posedge clock) begin
      amostra = d1;
      if (reset) begin
         mEstado      = OCIOSO;
         run          = 0;
         d0           = 1'b1;
         d1           = 1'b1;
         mDadoEntrada = 32'd0;
         mDisplay     = 32'd0;
         mValido      = 1'b0;
         modeloAtivo  = 1'b1;
      end else if (modeloAtivo) begin
         d1 = d0;
         d0 = es.enter;
         case (mEstado)
            OCIOSO: begin
               run = 0;
               if (es.pedidoEntrada) mEstado = ESPERA_SOLTA;
               else if (es.pedidoSaida) begin
                  mEstado  = SAIDA_ESPERA_SOLTA;
                  mDisplay = es.dadoSaidaBanco;
                  mValido  = 1'b1;
               end
            end
            ESCREVE: begin
               run     = 0;
               mEstado = OCIOSO;
            end
            default: begin
               aguardado = (mEstado == ESPERA_SOLTA || mEstado == SAIDA_ESPERA_SOLTA);
               if (amostra == aguardado) run++;
               else run = 0;
               if (run == DEB) begin
                  run = 0;
                  case (mEstado)
                     ESPERA_SOLTA:       mEstado = ESPERA_APERTO;
                     ESPERA_APERTO: begin
                        mEstado      = ESCREVE;
                        mDadoEntrada = 32'($signed(es.entradaSwitch));
                     end
                     SAIDA_ESPERA_SOLTA: mEstado = SAIDA_ESPERA_APERTO;
                     default:            mEstado = OCIOSO;
                  endcase
               end
            end
         endcase
      end
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clock) begin
      if (modeloAtivo) begin
         checkOutput("estado", 32'(es.estado), 32'(mEstado));
         checkOutput("dadoEntrada", es.dadoEntrada, mDadoEntrada);
         checkOutput("escreveBanco", 32'(es.escreveBanco), 32'(mEstado == ESCREVE));
         checkOutput("pcHabilita", 32'(es.pcHabilita),
                     32'(mEstado == OCIOSO && !es.pedidoEntrada && !es.pedidoSaida));
         checkOutput("dadoDisplay", es.dadoDisplay, mDisplay);
         checkOutput("displayValido", 32'(es.displayValido), 32'(mValido));
      end
      if (es.escreveBanco === 1'b1) writeCount++;
   end

   initial begin
      int w;
      int n;
      assertCount = 0;
      failCount   = 0;
      writeCount  = 0;
      reset       = 1'b1;
      applyStimulus(1'b1, 9'd0, 1'b0, 1'b0, 32'd0);
      tick(2);
      reset = 1'b0;
      checkOutput("resetEstado", 32'(es.estado), 32'(OCIOSO));
      checkOutput("resetDadoEntrada", es.dadoEntrada, 32'd0);
      checkOutput("resetDisplayValido", 32'(es.displayValido), 32'd0);
      checkOutput("resetPcHabilita", 32'(es.pcHabilita), 32'd1);

      // Basic input transaction with a negative switch value.
      es.entradaSwitch = 9'h1FB;
      es.pedidoEntrada = 1'b1;
      tick(1);
      es.pedidoEntrada = 1'b0;
      checkOutput("inEstadoSolta", 32'(es.estado), 32'(ESPERA_SOLTA));
      checkOutput("inPcParado", 32'(es.pcHabilita), 32'd0);
      waitEstado(ESPERA_APERTO, 20, "inEsperaAperto");
      w = writeCount;
      es.enter = 1'b0;
      waitEstado(ESCREVE, 20, "inEscreve");
      checkOutput("inDadoEntrada", es.dadoEntrada, 32'hFFFFFFFB);
      tick(1);
      checkOutput("inVoltaOcioso", 32'(es.estado), 32'(OCIOSO));
      checkOutput("inUmaEscrita", 32'(writeCount - w), 32'd1);

      // Bouncing button: no acceptance while toggling, then 2 sync + DEB stable cycles.
      es.enter = 1'b1;
      es.entradaSwitch = 9'h055;
      es.pedidoEntrada = 1'b1;
      tick(1);
      es.pedidoEntrada = 1'b0;
      waitEstado(ESPERA_APERTO, 20, "bounceEsperaAperto");
      for (int i = 0; i < 10; i++) begin
         es.enter = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      checkOutput("bounceSemAceite", 32'(es.estado), 32'(ESPERA_APERTO));
      es.enter = 1'b0;
      n = 0;
      while (es.estado !== 3'(ESCREVE) && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("bounceLatencia", 32'(n), 32'd6);
      checkOutput("bounceDado", es.dadoEntrada, 32'h00000055);
      tick(1);

      // Output with the button already held: display at once, release then fresh press needed.
      waitEstado(OCIOSO, 5, "heldOcioso");
      es.dadoSaidaBanco = 32'd123;
      es.pedidoSaida = 1'b1;
      tick(1);
      es.pedidoSaida = 1'b0;
      es.dadoSaidaBanco = 32'd77;
      checkOutput("heldDisplay", es.dadoDisplay, 32'd123);
      checkOutput("heldValido", 32'(es.displayValido), 32'd1);
      tick(20);
      checkOutput("heldEsperaSolta", 32'(es.estado), 32'(SAIDA_ESPERA_SOLTA));
      es.enter = 1'b1;
      waitEstado(SAIDA_ESPERA_APERTO, 20, "heldEsperaAperto");
      tick(10);
      checkOutput("heldPressNova", 32'(es.estado), 32'(SAIDA_ESPERA_APERTO));
      es.enter = 1'b0;
      waitEstado(OCIOSO, 20, "heldFim");
      checkOutput("heldDisplayMantido", es.dadoDisplay, 32'd123);

      // Both requests together: input path wins, display untouched.
      es.dadoSaidaBanco = 32'd55;
      es.pedidoEntrada = 1'b1;
      es.pedidoSaida = 1'b1;
      tick(1);
      es.pedidoEntrada = 1'b0;
      es.pedidoSaida = 1'b0;
      checkOutput("ambosEntrada", 32'(es.estado), 32'(ESPERA_SOLTA));
      es.enter = 1'b1;
      waitEstado(ESPERA_APERTO, 20, "ambosAperto");
      es.enter = 1'b0;
      waitEstado(OCIOSO, 20, "ambosFim");
      checkOutput("ambosDisplay", es.dadoDisplay, 32'd123);

      // Reset in the middle of a debounced press.
      es.enter = 1'b1;
      es.entradaSwitch = 9'h0AA;
      es.pedidoEntrada = 1'b1;
      tick(1);
      es.pedidoEntrada = 1'b0;
      waitEstado(ESPERA_APERTO, 20, "rstAperto");
      es.enter = 1'b0;
      tick(4);
      checkOutput("rstAindaAperto", 32'(es.estado), 32'(ESPERA_APERTO));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("rstEstado", 32'(es.estado), 32'(OCIOSO));
      checkOutput("rstDadoEntrada", es.dadoEntrada, 32'd0);
      checkOutput("rstDisplay", es.dadoDisplay, 32'd0);
      checkOutput("rstValido", 32'(es.displayValido), 32'd0);
      checkOutput("rstEscreve", 32'(es.escreveBanco), 32'd0);
      checkOutput("rstPc", 32'(es.pcHabilita), 32'd1);
      w = writeCount;
      tick(20);
      checkOutput("rstSemEscrita", 32'(writeCount - w), 32'd0);

      // Request held across two instructions: each needs its own release and press.
      es.enter = 1'b1;
      w = writeCount;
      es.pedidoEntrada = 1'b1;
      waitEstado(ESPERA_APERTO, 20, "b2bAperto1");
      es.enter = 1'b0;
      waitEstado(ESCREVE, 20, "b2bEscreve1");
      tick(15);
      checkOutput("b2bEsperaSolta", 32'(es.estado), 32'(ESPERA_SOLTA));
      es.enter = 1'b1;
      waitEstado(ESPERA_APERTO, 20, "b2bAperto2");
      es.enter = 1'b0;
      waitEstado(ESCREVE, 20, "b2bEscreve2");
      es.pedidoEntrada = 1'b0;
      tick(3);
      checkOutput("b2bDuasEscritas", 32'(writeCount - w), 32'd2);
      checkOutput("b2bOcioso", 32'(es.estado), 32'(OCIOSO));

      // Randomized phase: requests, bouncing button, data and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         applyStimulus(($urandom_range(0, 5) == 0) ? ~es.enter : es.enter,
                       9'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       $urandom);
         reset = ($urandom_range(0, 199) == 0);
         tick(1);
      end
      reset = 1'b0;
      applyStimulus(1'b1, 9'd0, 1'b0, 1'b0, 32'd0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/controlador_entrada_saida.md
CONTROLADOR_ENTRADA_SAIDA -- requirements
Module: controlador_entrada_saida

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 4: consecutive stable cycles needed to accept an enter press or release.
REQ-002 Parameter LARGURA_CONT, default 8: width of the debounce counter. DEBOUNCE_CICLOS SHALL be less than 2^LARGURA_CONT.
REQ-003 clock  input  1: single system clock. All state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-high.
REQ-005 enter  input  1: raw pushbutton, active-low (0 = pressed), asynchronous to clock.
REQ-006 entradaSwitch  input  9: two's-complement switch value.
REQ-007 pedidoEntrada  input  1: level from the control unit; current instruction is an input instruction.
REQ-008 pedidoSaida  input  1: level from the control unit; current instruction is an output instruction.
REQ-009 dadoSaidaBanco  input  32: register value to be displayed.
REQ-010 dadoEntrada  output  32: sign-extended latched switch value.
REQ-011 escreveBanco  output  1: one-cycle register-bank write strobe.
REQ-012 pcHabilita  output  1: 1 = program counter may advance; 0 = stall.
REQ-013 dadoDisplay  output  32: value held for the display decoder.
REQ-014 displayValido  output  1: 1 while dadoDisplay holds a valid output value.
REQ-015 estado  output  3: current FSM state encoding, for debug.

Function
REQ-016 enter SHALL pass through a two-flop synchronizer before any use. Latency is 2 cycles.
REQ-017 The FSM SHALL have these states: OCIOSO, ESPERA_SOLTA, ESPERA_APERTO, ESCREVE, SAIDA_ESPERA_SOLTA, SAIDA_ESPERA_APERTO.
REQ-018 OCIOSO: pcHabilita=1. Transitions:
- pedidoEntrada=1 -> ESPERA_SOLTA.
- Otherwise, pedidoSaida=1 -> SAIDA_ESPERA_SOLTA.
- pedidoEntrada has priority when both are asserted.
REQ-019 pcHabilita SHALL be 0 in every state except OCIOSO. It SHALL also be 0 in the cycle OCIOSO is left.
REQ-020 ESPERA_SOLTA / SAIDA_ESPERA_SOLTA: wait until the synchronized enter reads 1 (released) for DEBOUNCE_CICLOS consecutive cycles. Then go to the matching ESPERA_APERTO state.
REQ-021 ESPERA_APERTO / SAIDA_ESPERA_APERTO: wait until the synchronized enter reads 0 (pressed) for DEBOUNCE_CICLOS consecutive cycles.
REQ-022 The debounce counter SHALL clear on any sample that disagrees with the awaited level. It SHALL clear on every state change. It SHALL saturate and never wrap.
REQ-023 On the accepting cycle of ESPERA_APERTO:
- dadoEntrada <= sign-extend(entradaSwitch) to 32 bits, i.e. bit 8 replicated into bits 31:9.
- Next state is ESCREVE.
REQ-024 ESCREVE SHALL last exactly 1 cycle. In it, escreveBanco=1, then the FSM returns to OCIOSO. escreveBanco SHALL be 0 in all other states.
REQ-025 On entering SAIDA_ESPERA_SOLTA: dadoDisplay <= dadoSaidaBanco, and displayValido <= 1.
REQ-026 On the accepting cycle of SAIDA_ESPERA_APERTO, the FSM SHALL return to OCIOSO. dadoDisplay and displayValido SHALL hold until the next output instruction or reset.
REQ-027 If enter is held pressed at request time, the block SHALL wait for a release first. One physical press SHALL never complete two instructions.
REQ-028 pedidoEntrada and pedidoSaida SHALL be ignored outside OCIOSO. On return to OCIOSO, a still-asserted request SHALL start a new transaction the next cycle.
REQ-029 dadoEntrada SHALL change only as per REQ-023.

Reset
REQ-030 Reset SHALL force the following on the next rising edge, from any state including mid-transaction:
- state = OCIOSO, counter = 0, synchronizer flops = 1.
- dadoEntrada = 0, dadoDisplay = 0, displayValido = 0, escreveBanco = 0, pcHabilita = 1.
REQ-031 An interrupted transaction SHALL produce no escreveBanco pulse after reset.

Structure
REQ-032 The state encodings (3-bit constants) SHALL live in the shared definitions include file used by the control unit, so estado can be decoded consistently.
REQ-033 One sub-module, sincronizadorDebounce, SHALL hold the synchronizer, counter and level comparison. It takes the awaited level and outputs a one-cycle "estavel" pulse. The FSM SHALL be in the top module.
REQ-034 The design SHALL contain no latches, no gated clocks and no asynchronous reset.

Verification
REQ-035 Input transaction, DEBOUNCE_CICLOS=4:
- Stimulus: enter released, pedidoEntrada=1, switches=9'h1FB, then press enter.
- Response: pcHabilita=0 until ESCREVE; dadoEntrada=32'hFFFFFFFB; exactly one escreveBanco pulse; return to OCIOSO.
REQ-036 Bounce:
- Stimulus: while in ESPERA_APERTO, enter toggles 0/1 every 2 cycles for 20 cycles, then held at 0.
- Response: no acceptance during toggling; acceptance exactly 2+4 cycles after the hold begins.
REQ-037 Held button:
- Stimulus: enter held pressed at pedidoSaida=1 with dadoSaidaBanco=123.
- Response: dadoDisplay=123 and displayValido=1 immediately; FSM stays in SAIDA_ESPERA_SOLTA until a release, then requires a fresh press.
REQ-038 Simultaneous requests:
- Stimulus: pedidoEntrada=1 and pedidoSaida=1 in OCIOSO.
- Response: input path taken; dadoDisplay unchanged.
REQ-039 Reset mid-operation:
- Stimulus: reset asserted for 1 cycle in ESPERA_APERTO after 2 stable pressed cycles.
- Response: all outputs at REQ-030 values; no escreveBanco afterwards.
REQ-040 Back-to-back input:
- Stimulus: pedidoEntrada held high across two input instructions.
- Response: each instruction requires its own release and press; exactly two escreveBanco pulses.
